// File: rtl/program_sequencer_stack_if.sv
// ---------------------------------------------------------------------------
// program_sequencer_stack_if
//   Decoder/sequencer bundle for the program sequencer. The decoder side
//   (master) drives the control requests and the jump target. The sequencer
//   (slave) returns the fetch address, the PC and the return-stack status.
//
//   Signals (master -> slave):
//     hold      stall; PC and stack frozen
//     jmp       unconditional jump
//     jmp_nz    jump when dont_jmp==0
//     dont_jmp  zero flag from the computational unit
//     call      push return address, then jump
//     ret       pop return address into PC
//     jmp_addr  [TW]  low bits of the jump/call target
//   Signals (slave -> master):
//     pm_addr   [AW]  combinational next fetch address
//     pc        [AW]  registered PC
//     sp        [SPW] number of valid stack entries
//     stack_full, stack_empty, stack_err
// ---------------------------------------------------------------------------
interface program_sequencer_stack_if #(
  parameter int AW  = 8,
  parameter int TW  = 4,
  parameter int SPW = 3
);
  logic           hold;
  logic           jmp;
  logic           jmp_nz;
  logic           dont_jmp;
  logic           call;
  logic           ret;
  logic [TW-1:0]  jmp_addr;
  logic [AW-1:0]  pm_addr;
  logic [AW-1:0]  pc;
  logic [SPW-1:0] sp;
  logic           stack_full;
  logic           stack_empty;
  logic           stack_err;

  modport master (
    output hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
    input  pm_addr, pc, sp, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
    output pm_addr, pc, sp, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/program_sequencer_stack.sv
// ---------------------------------------------------------------------------
// program_sequencer_stack
//   Program sequencer with a hardware return stack. Produces the next
//   program-memory fetch address combinationally and registers it as the PC
//   on every rising edge. Supports jmp, jmp_nz, call and ret with a fixed
//   priority: reset > hold > ret > call > jmp > jmp_nz > increment.
//
//   Ports:
//     clk         clock; all state updates on posedge
//     sync_reset  synchronous active-high reset (pc, sp and error cleared)
//     bus         program_sequencer_stack_if.slave (controls in, status out)
//
//   Parameters:
//     AW     program address width
//     TW     jump-target width (TW<=AW); target is page-relative to the PC
//     DEPTH  return-stack entries (>=1)
//     SPW    stack-pointer width, 2**SPW > DEPTH
// ---------------------------------------------------------------------------
module program_sequencer_stack #(
  parameter int AW    = 8,
  parameter int TW    = 4,
  parameter int DEPTH = 4,
  parameter int SPW   = 3
) (
  input  logic                      clk,
  input  logic                      sync_reset,
  program_sequencer_stack_if.slave  bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [AW-1:0]  r_pc;
  logic [SPW-1:0] r_sp;
  logic           r_err;
  logic [AW-1:0]  r_stack [DEPTH];

  logic [AW-1:0]  w_pc_inc;
  logic [AW-1:0]  w_tgt;
  logic [AW-1:0]  w_pm_addr;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_err_set;
  logic [IW-1:0]  w_push_idx;
  logic [IW-1:0]  w_top_idx;

  // Natural AW-bit width makes the increment wrap from all-ones to zero,
  // and the pushed return address wraps the same way.
  assign w_pc_inc = r_pc + 1'b1;

  // Target keeps the upper PC bits (same page); full-width target is absolute.
  generate
    if (TW == AW) begin : g_abs_tgt
      assign w_tgt = bus.jmp_addr;
    end else begin : g_page_tgt
      assign w_tgt = {r_pc[AW-1:TW], bus.jmp_addr};
    end
  endgenerate

  assign w_full     = (r_sp == SP_FULL);
  assign w_empty    = (r_sp == '0);
  assign w_push_idx = IW'(r_sp);
  assign w_top_idx  = IW'(r_sp - 1'b1);

  // Next-address selection in strict priority order; lower-priority requests
  // are simply ignored in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    w_pm_addr = w_pc_inc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    if (sync_reset) begin
      w_pm_addr = '0;
    end else if (bus.hold) begin
      w_pm_addr = r_pc;
    end else if (bus.ret) begin
      if (!w_empty) begin
        w_pm_addr = r_stack[w_top_idx];
        w_pop     = 1'b1;
      end else begin
        w_err_set = 1'b1;                 // underflow: behaves as a NOP
      end
    end else if (bus.call) begin
      if (!w_full) begin
        w_pm_addr = w_tgt;
        w_push    = 1'b1;
      end else begin
        w_err_set = 1'b1;                 // overflow: behaves as a NOP
      end
    end else if (bus.jmp) begin
      w_pm_addr = w_tgt;
    end else if (bus.jmp_nz && !bus.dont_jmp) begin
      w_pm_addr = w_tgt;
    end
  end

  // Control state: PC, stack pointer and sticky error flag.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (sync_reset) begin
      r_pc  <= '0;
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc <= w_pm_addr;
      if (w_push) begin
        r_sp <= r_sp + 1'b1;
      end else if (w_pop) begin
        r_sp <= r_sp - 1'b1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // NOTE: stack storage has no reset; entries above sp are never read, so
  // clearing them would only add reset fan-out to a plain register file.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign bus.pm_addr     = w_pm_addr;
  assign bus.pc          = r_pc;
  assign bus.sp          = r_sp;
  assign bus.stack_full  = w_full;
  assign bus.stack_empty = w_empty;
  assign bus.stack_err   = r_err;

endmodule

// File: tb/tb_program_sequencer_stack.sv
// ---------------------------------------------------------------------------
// tb_program_sequencer_stack
//   Directed bench for program_sequencer_stack (AW=8, TW=4, DEPTH=4, SPW=3).
//   Inputs change 1 ns after a rising edge; pm_addr is sampled 1 ns later,
//   registered outputs 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_program_sequencer_stack;

  logic clk;
  logic sync_reset;
  int   checks;
  int   failures;

  program_sequencer_stack_if #(.AW(8), .TW(4), .SPW(3)) bus ();

  program_sequencer_stack #(.AW(8), .TW(4), .DEPTH(4), .SPW(3)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply a control vector and let the combinational path settle.
  task automatic drive(input logic h, input logic j, input logic jn, input logic dj,
                       input logic c, input logic r, input logic [3:0] a);
    bus.hold     = h;
    bus.jmp      = j;
    bus.jmp_nz   = jn;
    bus.dont_jmp = dj;
    bus.call     = c;
    bus.ret      = r;
    bus.jmp_addr = a;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 4'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    sync_reset = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // 1: reset and increment
    check("rst_pm", 32'(bus.pm_addr), 0);
    step();
    check("rst_pc", 32'(bus.pc), 0);
    check("rst_sp", 32'(bus.sp), 0);
    check("rst_empty", 32'(bus.stack_empty), 1);
    check("rst_full", 32'(bus.stack_full), 0);
    check("rst_err", 32'(bus.stack_err), 0);
    sync_reset = 1'b0;
    idle();
    for (int i = 1; i <= 5; i++) begin
      check("inc_pm", 32'(bus.pm_addr), 32'(i));
      step();
      check("inc_pc", 32'(bus.pc), 32'(i));
    end
    check("inc_sp", 32'(bus.sp), 0);

    // 2: jumps (pc 5 -> 0x23)
    idle_steps(30);
    check("pos_pc23", 32'(bus.pc), 32'h23);
    drive(0, 1, 0, 0, 0, 0, 4'h9);
    check("jmp_pm", 32'(bus.pm_addr), 32'h29);
    step();
    check("jmp_pc", 32'(bus.pc), 32'h29);
    drive(0, 0, 1, 1, 0, 0, 4'h2);
    check("jnz_taken_not", 32'(bus.pm_addr), 32'h2A);
    step();
    drive(0, 0, 1, 0, 0, 0, 4'h2);
    check("jnz_taken", 32'(bus.pm_addr), 32'h22);
    step();
    check("jnz_pc", 32'(bus.pc), 32'h22);

    // 3: call/ret from pc 0x10
    sync_reset = 1'b1;
    idle();
    step();
    sync_reset = 1'b0;
    idle_steps(16);
    check("pos_pc10", 32'(bus.pc), 32'h10);
    drive(0, 0, 0, 0, 1, 0, 4'h5);
    check("call_pm", 32'(bus.pm_addr), 32'h15);
    step();
    check("call_sp", 32'(bus.sp), 1);
    check("call_empty", 32'(bus.stack_empty), 0);
    idle_steps(1);
    check("sub_pc", 32'(bus.pc), 32'h16);
    drive(0, 0, 0, 0, 0, 1, 4'h0);
    check("ret_pm", 32'(bus.pm_addr), 32'h11);
    step();
    check("ret_sp", 32'(bus.sp), 0);
    check("ret_empty", 32'(bus.stack_empty), 1);

    // 4: nesting and overflow/underflow, starting at pc 0x11
    drive(0, 0, 0, 0, 1, 0, 4'h0); step();   // push 0x12 -> pc 0x10
    drive(0, 0, 0, 0, 1, 0, 4'h4); step();   // push 0x11 -> pc 0x14
    drive(0, 0, 0, 0, 1, 0, 4'h8); step();   // push 0x15 -> pc 0x18
    drive(0, 0, 0, 0, 1, 0, 4'hC);
    check("call4_pm", 32'(bus.pm_addr), 32'h1C);
    step();                                  // push 0x19 -> pc 0x1C
    check("nest_sp", 32'(bus.sp), 4);
    check("nest_full", 32'(bus.stack_full), 1);
    check("nest_err0", 32'(bus.stack_err), 0);
    drive(0, 0, 0, 0, 1, 0, 4'h3);
    check("ovf_pm", 32'(bus.pm_addr), 32'h1D);
    step();
    check("ovf_sp", 32'(bus.sp), 4);
    check("ovf_err", 32'(bus.stack_err), 1);
    drive(0, 0, 0, 0, 0, 1, 4'h0);
    check("pop1", 32'(bus.pm_addr), 32'h19);
    step();
    check("pop1_sp", 32'(bus.sp), 3);
    check("pop2", 32'(bus.pm_addr), 32'h15);
    step();
    check("pop3", 32'(bus.pm_addr), 32'h11);
    step();
    check("pop4", 32'(bus.pm_addr), 32'h12);
    step();
    check("pop4_empty", 32'(bus.stack_empty), 1);
    check("udf_pm", 32'(bus.pm_addr), 32'h13);
    step();
    check("udf_sp", 32'(bus.sp), 0);
    check("udf_err", 32'(bus.stack_err), 1);

    // 5: priority and hold, starting at pc 0x13
    drive(0, 0, 0, 0, 1, 0, 4'h7);
    step();                                  // push 0x14 -> pc 0x17
    drive(1, 1, 0, 0, 1, 0, 4'h2);
    check("hold_pm", 32'(bus.pm_addr), 32'h17);
    step();
    check("hold_pc", 32'(bus.pc), 32'h17);
    check("hold_sp", 32'(bus.sp), 1);
    drive(0, 1, 0, 0, 1, 1, 4'h2);
    check("prio_pm", 32'(bus.pm_addr), 32'h14);
    step();
    check("prio_sp", 32'(bus.sp), 0);
    idle_steps(235);
    check("pos_pcFF", 32'(bus.pc), 32'hFF);
    check("wrap_pm", 32'(bus.pm_addr), 32'h00);
    drive(0, 0, 0, 0, 1, 0, 4'h6);
    check("callFF_pm", 32'(bus.pm_addr), 32'hF6);
    step();
    drive(0, 0, 0, 0, 0, 1, 4'h0);
    check("retwrap_pm", 32'(bus.pm_addr), 32'h00);
    step();

    // 6: reset mid-subroutine with sp=3 and err set
    drive(0, 0, 0, 0, 1, 0, 4'h1); step();
    drive(0, 0, 0, 0, 1, 0, 4'h2); step();
    drive(0, 0, 0, 0, 1, 0, 4'h3); step();
    check("mid_sp", 32'(bus.sp), 3);
    check("mid_err", 32'(bus.stack_err), 1);
    sync_reset = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 4'h4);
    check("mid_rst_pm", 32'(bus.pm_addr), 0);
    step();
    check("mid_rst_pc", 32'(bus.pc), 0);
    check("mid_rst_sp", 32'(bus.sp), 0);
    check("mid_rst_err", 32'(bus.stack_err), 0);
    sync_reset = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 4'h0);
    check("post_udf_pm", 32'(bus.pm_addr), 1);
    step();
    check("post_udf_err", 32'(bus.stack_err), 1);
    check("post_udf_sp", 32'(bus.sp), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
